// File: rtl/sdpram_pkg.sv
// sdpram_pkg
//   Shared types and helpers for the sdpram_pipe storage block.
//   - state_t      : control FSM states (INIT sweep, READY for traffic)
//   - RL_MIN/RL_MAX: legal range of READ_LATENCY
//   - lane_merge() : byte-lane merge of a new word over an old word, used by
//                    the write-first bypass path and by reference models.
//                    Operands are carried at a fixed maximum width so that one
//                    function serves every DATA_WIDTH/BYTE_WIDTH combination.
//                    Callers zero-extend the operands and truncate the result.
package sdpram_pkg;

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam int RL_MIN = 1;
  localparam int RL_MAX = 4;

  localparam int LM_DW = 1024;
  localparam int LM_NB = 128;

  // Lanes whose enable bit is set take new_w; all other lanes keep old_w.
  function automatic logic [LM_DW-1:0] lane_merge(
    input logic [LM_DW-1:0] old_w,
    input logic [LM_DW-1:0] new_w,
    input logic [LM_NB-1:0] be,
    input int unsigned      bw
  );
    logic [LM_DW-1:0] mask;
    logic [LM_DW-1:0] lane;
    mask = '0;
    lane = (LM_DW'(1) << bw) - LM_DW'(1);
    for (int i = 0; i < LM_NB; i++) begin
      if (be[i]) mask = mask | (lane << (i * bw));
    end
    return (new_w & mask) | (old_w & ~mask);
  endfunction

endpackage

// File: rtl/sdpram_rd_pipe.sv
// sdpram_rd_pipe
//   Delay line that carries read data, its valid bit and its collision flag
//   through DEPTH registered stages (DEPTH >= 1). Data registers only load
//   when the incoming stage is valid, so the output word holds its last value
//   between valid strobes. Everything clears on reset so that reads in flight
//   are discarded and the output word returns to zero.
//   Ports:
//     clk, rst        clock, asynchronous active-high reset
//     din/vld_in/coll_in    stage input (array read register)
//     dout/vld_out/coll_out delayed output
module sdpram_rd_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  vld_in,
  input  logic                  coll_in,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  vld_out,
  output logic                  coll_out
);

  logic [DATA_WIDTH-1:0] data_pn [DEPTH];
  logic                  vld_pn  [DEPTH];
  logic                  coll_pn [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        data_pn[k] <= '0;
        vld_pn[k]  <= 1'b0;
        coll_pn[k] <= 1'b0;
      end
    end else begin
      vld_pn[0]  <= vld_in;
      coll_pn[0] <= coll_in;
      if (vld_in) data_pn[0] <= din;
      for (int k = 1; k < DEPTH; k++) begin
        vld_pn[k]  <= vld_pn[k-1];
        coll_pn[k] <= coll_pn[k-1];
        if (vld_pn[k-1]) data_pn[k] <= data_pn[k-1];
      end
    end
  end

  assign dout     = data_pn[DEPTH-1];
  assign vld_out  = vld_pn[DEPTH-1];
  assign coll_out = coll_pn[DEPTH-1];

endmodule

// File: rtl/sdpram_pipe.sv
// sdpram_pipe
//   Simple dual-port RAM on one clock: a byte-enabled write port and a read
//   port with READ_LATENCY (1..4) registered stages and a valid strobe.
//   After reset an init sweep writes INIT_VALUE to every word (init_busy high)
//   before any traffic is accepted. A read and write to the same in-range
//   address in one cycle raises coll alongside that read's valid strobe.
//   Build option: define SDPRAM_BYPASS_EN for write-first collisions (the
//   read returns the write merged by byte lane over the old word); otherwise
//   a colliding read returns the old word.
//   Ports:
//     clk, rst                 clock, asynchronous active-high reset
//     init_busy                high while the init sweep runs
//     wena, addra, dina, wbe   write request, address, data, lane enables
//     renb, addrb              read request and address
//     doutb, doutb_valid, coll read data, valid strobe, collision flag
module sdpram_pipe
  import sdpram_pkg::*;
#(
  parameter int                   DATA_WIDTH   = 32,
  parameter int                   BYTE_WIDTH   = 8,
  parameter int                   MEM_DEPTH    = 256,
  parameter int                   ADDR_WIDTH   = $clog2(MEM_DEPTH),
  parameter int                   READ_LATENCY = 2,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE  = '0,
  localparam int                  NB           = DATA_WIDTH / BYTE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  init_busy,
  input  logic                  wena,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [DATA_WIDTH-1:0] dina,
  input  logic [NB-1:0]         wbe,
  input  logic                  renb,
  input  logic [ADDR_WIDTH-1:0] addrb,
  output logic [DATA_WIDTH-1:0] doutb,
  output logic                  doutb_valid,
  output logic                  coll
);

  // Out-of-range latencies are clamped to the legal range.
  localparam int RL_EFF     = (READ_LATENCY < RL_MIN) ? RL_MIN :
                              (READ_LATENCY > RL_MAX) ? RL_MAX : READ_LATENCY;
  localparam int PIPE_DEPTH = RL_EFF - 1;

  state_t                state;
  logic [ADDR_WIDTH-1:0] sweep_cnt;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic                  ready;
  logic                  wr_in_rng, rd_in_rng;
  logic                  wr_acc, rd_acc, coll_now;
  logic [DATA_WIDTH-1:0] rd_old, rd_word;

  logic [DATA_WIDTH-1:0] data_p0;
  logic                  vld_p0;
  logic                  coll_p0;

  assign ready     = (state == ST_READY);
  assign init_busy = ~ready;
  assign wr_in_rng = 32'(addra) < MEM_DEPTH;
  assign rd_in_rng = 32'(addrb) < MEM_DEPTH;
  assign wr_acc    = ready & wena & wr_in_rng;
  assign rd_acc    = ready & renb;
  // An in-range write matching the read address implies an in-range read.
  assign coll_now  = rd_acc & wr_acc & (addra == addrb);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_INIT;
      sweep_cnt <= '0;
    end else if (state == ST_INIT) begin
      sweep_cnt <= sweep_cnt + ADDR_WIDTH'(1);
      if (sweep_cnt == ADDR_WIDTH'(MEM_DEPTH - 1)) state <= ST_READY;
    end
  end

  // The array itself is never reset; the sweep owns the write port in INIT.
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      mem[sweep_cnt] <= INIT_VALUE;
    end else if (wr_acc) begin
      for (int i = 0; i < NB; i++) begin
        if (wbe[i]) mem[addra][i*BYTE_WIDTH +: BYTE_WIDTH] <= dina[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  always_comb begin
    rd_old  = rd_in_rng ? mem[addrb] : '0;
    rd_word = rd_old;
`ifdef SDPRAM_BYPASS_EN
    if (coll_now) begin
      rd_word = DATA_WIDTH'(lane_merge(LM_DW'(rd_old), LM_DW'(dina), LM_NB'(wbe), BYTE_WIDTH));
    end
`endif
  end

  // Stage 1: array read register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0  <= 1'b0;
      coll_p0 <= 1'b0;
      data_p0 <= '0;
    end else begin
      vld_p0  <= rd_acc;
      coll_p0 <= coll_now;
      if (rd_acc) data_p0 <= rd_word;
    end
  end

  // Stages 2..READ_LATENCY: delay line
  generate
    if (PIPE_DEPTH == 0) begin : g_no_pipe
      assign doutb       = data_p0;
      assign doutb_valid = vld_p0;
      assign coll        = coll_p0;
    end else begin : g_pipe
      sdpram_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (PIPE_DEPTH)
      ) u_rd_pipe (
        .clk      (clk),
        .rst      (rst),
        .din      (data_p0),
        .vld_in   (vld_p0),
        .coll_in  (coll_p0),
        .dout     (doutb),
        .vld_out  (doutb_valid),
        .coll_out (coll)
      );
    end
  endgenerate

endmodule

// File: tb/tb_sdpram_pipe.sv
// tb_sdpram_pipe
//   Directed bench for sdpram_pipe. Five instances share one stimulus:
//     0: depth 256, latency 2   1: depth 256, latency 1
//     2: depth 256, latency 3   3: depth 256, latency 4
//     4: depth 200, latency 2 (addresses 200..255 out of range)
//   All use INIT_VALUE 32'hDEAD_BEEF. Honors SDPRAM_BYPASS_EN for collision data.
module tb_sdpram_pipe;
  import sdpram_pkg::*;

  localparam int NDUT = 5;
  localparam logic [31:0] IV = 32'hDEAD_BEEF;
  localparam int LAT [NDUT] = '{2, 1, 3, 4, 2};
  localparam int DEP [NDUT] = '{256, 256, 256, 256, 200};

  logic        clk_tb = 1'b0;
  logic        rst;
  logic        wena, renb;
  logic [7:0]  addra, addrb;
  logic [31:0] dina;
  logic [3:0]  wbe;

  logic [31:0] doutb_a [NDUT];
  logic        valid_a [NDUT];
  logic        coll_a  [NDUT];
  logic        busy_a  [NDUT];

  int checks = 0;
  int errors = 0;

  int          got_cyc [NDUT];
  logic [31:0] got_d   [NDUT];
  logic        got_c   [NDUT];
  int          sweep_cnt [NDUT];
  bit          sweep_vld;

  always #5 clk_tb = ~clk_tb;

  sdpram_pipe #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .MEM_DEPTH(256), .READ_LATENCY(2), .INIT_VALUE(IV)) u_main (
    .clk(clk_tb), .rst(rst), .init_busy(busy_a[0]), .wena(wena), .addra(addra), .dina(dina), .wbe(wbe),
    .renb(renb), .addrb(addrb), .doutb(doutb_a[0]), .doutb_valid(valid_a[0]), .coll(coll_a[0]));
  sdpram_pipe #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .MEM_DEPTH(256), .READ_LATENCY(1), .INIT_VALUE(IV)) u_l1 (
    .clk(clk_tb), .rst(rst), .init_busy(busy_a[1]), .wena(wena), .addra(addra), .dina(dina), .wbe(wbe),
    .renb(renb), .addrb(addrb), .doutb(doutb_a[1]), .doutb_valid(valid_a[1]), .coll(coll_a[1]));
  sdpram_pipe #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .MEM_DEPTH(256), .READ_LATENCY(3), .INIT_VALUE(IV)) u_l3 (
    .clk(clk_tb), .rst(rst), .init_busy(busy_a[2]), .wena(wena), .addra(addra), .dina(dina), .wbe(wbe),
    .renb(renb), .addrb(addrb), .doutb(doutb_a[2]), .doutb_valid(valid_a[2]), .coll(coll_a[2]));
  sdpram_pipe #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .MEM_DEPTH(256), .READ_LATENCY(4), .INIT_VALUE(IV)) u_l4 (
    .clk(clk_tb), .rst(rst), .init_busy(busy_a[3]), .wena(wena), .addra(addra), .dina(dina), .wbe(wbe),
    .renb(renb), .addrb(addrb), .doutb(doutb_a[3]), .doutb_valid(valid_a[3]), .coll(coll_a[3]));
  sdpram_pipe #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .MEM_DEPTH(200), .READ_LATENCY(2), .INIT_VALUE(IV)) u_d200 (
    .clk(clk_tb), .rst(rst), .init_busy(busy_a[4]), .wena(wena), .addra(addra), .dina(dina), .wbe(wbe),
    .renb(renb), .addrb(addrb), .doutb(doutb_a[4]), .doutb_valid(valid_a[4]), .coll(coll_a[4]));

  task automatic step();
    @(posedge clk_tb);
    #1;
  endtask

  // Runs until every instance leaves the sweep, counting busy cycles per
  // instance. With poke set, reads and writes are driven early in the sweep
  // (while every instance is still busy) and must have no effect.
  task automatic run_sweep(input bit poke);
    bit any;
    int k;
    for (int i = 0; i < NDUT; i++) sweep_cnt[i] = 0;
    sweep_vld = 1'b0;
    k = 0;
    any = 1'b1;
    while (any && k < 2000) begin
      if (poke) begin
        renb = (k < 150); addrb = 8'h00;
        wena = (k >= 10 && k < 50); addra = 8'h00; dina = 32'h0; wbe = 4'hF;
      end
      for (int i = 0; i < NDUT; i++) begin
        if (busy_a[i]) sweep_cnt[i]++;
        if (busy_a[i] && valid_a[i]) sweep_vld = 1'b1;
      end
      step();
      k++;
      any = 1'b0;
      for (int i = 0; i < NDUT; i++) if (busy_a[i]) any = 1'b1;
    end
    wena = 1'b0;
    renb = 1'b0;
  endtask

  // Drives one cycle of stimulus, then watches up to six edges and records
  // the first valid strobe of each instance with the edge count at which it
  // appeared (1 = the edge that accepted the request).
  task automatic txn(input logic we, input logic [7:0] wa, input logic [31:0] wd,
                     input logic [3:0] be, input logic re, input logic [7:0] ra);
    wena = we; addra = wa; dina = wd; wbe = be; renb = re; addrb = ra;
    for (int i = 0; i < NDUT; i++) got_cyc[i] = -1;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c == 1) begin wena = 1'b0; renb = 1'b0; end
      for (int i = 0; i < NDUT; i++) begin
        if (valid_a[i] && got_cyc[i] < 0) begin
          got_cyc[i] = c; got_d[i] = doutb_a[i]; got_c[i] = coll_a[i];
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    for (int i = 0; i < NDUT; i++) begin
      checks++;
      if ({busy_a[i], valid_a[i], coll_a[i], doutb_a[i]} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
        errors++;
        $display("FAIL reset_state dut%0d: got busy=%b v=%b c=%b d=%h, expected busy=1 v=0 c=0 d=00000000",
                 i, busy_a[i], valid_a[i], coll_a[i], doutb_a[i]);
      end
    end
    rst = 1'b0;
    run_sweep(1'b1);
    for (int i = 0; i < NDUT; i++) begin
      checks++;
      if (sweep_cnt[i] != DEP[i]) begin
        errors++;
        $display("FAIL sweep_len dut%0d: got %0d busy cycles, expected %0d", i, sweep_cnt[i], DEP[i]);
      end
    end
    checks++;
    if (sweep_vld !== 1'b0) begin
      errors++;
      $display("FAIL sweep_no_valid: got valid during sweep, expected none");
    end
  endtask

  task automatic test_init_sweep();
    logic [31:0] exp_d;
    txn(1'b0, 8'h00, 32'h0, 4'h0, 1'b1, 8'h00);
    for (int i = 0; i < NDUT; i++) begin
      checks++;
      if (got_cyc[i] != LAT[i] || got_d[i] !== IV || got_c[i] !== 1'b0) begin
        errors++;
        $display("FAIL init_rd00 dut%0d: got cyc=%0d d=%h c=%b, expected cyc=%0d d=%h c=0",
                 i, got_cyc[i], got_d[i], got_c[i], LAT[i], IV);
      end
    end
    txn(1'b0, 8'h00, 32'h0, 4'h0, 1'b1, 8'hFF);
    for (int i = 0; i < NDUT; i++) begin
      exp_d = (i == 4) ? 32'h0 : IV;
      checks++;
      if (got_cyc[i] != LAT[i] || got_d[i] !== exp_d || got_c[i] !== 1'b0) begin
        errors++;
        $display("FAIL init_rdFF dut%0d: got cyc=%0d d=%h c=%b, expected cyc=%0d d=%h c=0",
                 i, got_cyc[i], got_d[i], got_c[i], LAT[i], exp_d);
      end
    end
  endtask

  task automatic test_byte_enables();
    logic [31:0] exp_d;
    txn(1'b1, 8'h10, 32'h1122_3344, 4'hF, 1'b0, 8'h00);
    txn(1'b1, 8'h10, 32'hAABB_CCDD, 4'b0101, 1'b0, 8'h00);
    txn(1'b0, 8'h00, 32'h0, 4'h0, 1'b1, 8'h10);
    for (int i = 0; i < NDUT; i++) begin
      checks++;
      if (got_cyc[i] != LAT[i] || got_d[i] !== 32'h11BB_33DD) begin
        errors++;
        $display("FAIL byte_en dut%0d: got cyc=%0d d=%h, expected cyc=%0d d=11bb33dd", i, got_cyc[i], got_d[i], LAT[i]);
      end
    end
    txn(1'b1, 8'h10, 32'hFFFF_FFFF, 4'h0, 1'b0, 8'h00);
    txn(1'b0, 8'h00, 32'h0, 4'h0, 1'b1, 8'h10);
    for (int i = 0; i < NDUT; i++) begin
      checks++;
      if (got_d[i] !== 32'h11BB_33DD) begin
        errors++;
        $display("FAIL wbe_zero dut%0d: got d=%h, expected d=11bb33dd", i, got_d[i]);
      end
    end
    txn(1'b1, 8'hC8, 32'h1234_5678, 4'hF, 1'b0, 8'h00);
    txn(1'b0, 8'h00, 32'h0, 4'h0, 1'b1, 8'hC8);
    for (int i = 0; i < NDUT; i++) begin
      exp_d = (i == 4) ? 32'h0 : 32'h1234_5678;
      checks++;
      if (got_cyc[i] != LAT[i] || got_d[i] !== exp_d) begin
        errors++;
        $display("FAIL out_of_range dut%0d: got cyc=%0d d=%h, expected cyc=%0d d=%h", i, got_cyc[i], got_d[i], LAT[i], exp_d);
      end
    end
  endtask

  task automatic test_latency();
    int k [NDUT];
    logic [31:0] exp_d;
    for (int a = 1; a <= 8; a++) txn(1'b1, 8'(a), {16'hC0DE, 8'h00, 8'(a)}, 4'hF, 1'b0, 8'h00);
    for (int i = 0; i < NDUT; i++) k[i] = 0;
    wena = 1'b0; renb = 1'b1; addrb = 8'h01;
    for (int c = 1; c <= 14; c++) begin
      step();
      for (int i = 0; i < NDUT; i++) begin
        if (valid_a[i]) begin
          exp_d = {16'hC0DE, 8'h00, 8'(k[i] + 1)};
          checks++;
          if (k[i] >= 8 || c != LAT[i] + k[i] || doutb_a[i] !== exp_d) begin
            errors++;
            $display("FAIL latency_pulse dut%0d: got cyc=%0d d=%h, expected cyc=%0d d=%h",
                     i, c, doutb_a[i], LAT[i] + k[i], exp_d);
          end
          k[i]++;
        end
      end
      if (c < 8) addrb = 8'(c + 1);
      else renb = 1'b0;
    end
    for (int i = 0; i < NDUT; i++) begin
      checks++;
      if (k[i] != 8) begin
        errors++;
        $display("FAIL latency_count dut%0d: got %0d pulses, expected 8", i, k[i]);
      end
    end
  endtask

  task automatic test_collision();
    logic [31:0] exp_d;
    logic        exp_c;
    txn(1'b1, 8'h20, 32'h0, 4'hF, 1'b0, 8'h00);
`ifdef SDPRAM_BYPASS_EN
    exp_d = 32'hFFFF_FFFF;
`else
    exp_d = 32'h0000_0000;
`endif
    txn(1'b1, 8'h20, 32'hFFFF_FFFF, 4'hF, 1'b1, 8'h20);
    for (int i = 0; i < NDUT; i++) begin
      checks++;
      if (got_cyc[i] != LAT[i] || got_d[i] !== exp_d || got_c[i] !== 1'b1) begin
        errors++;
        $display("FAIL coll_full dut%0d: got cyc=%0d d=%h c=%b, expected cyc=%0d d=%h c=1",
                 i, got_cyc[i], got_d[i], got_c[i], LAT[i], exp_d);
      end
    end
    txn(1'b1, 8'h20, 32'h1234_5678, 4'h0, 1'b1, 8'h20);
    for (int i = 0; i < NDUT; i++) begin
      checks++;
      if (got_d[i] !== 32'hFFFF_FFFF || got_c[i] !== 1'b1) begin
        errors++;
        $display("FAIL coll_wbe0 dut%0d: got d=%h c=%b, expected d=ffffffff c=1", i, got_d[i], got_c[i]);
      end
    end
`ifdef SDPRAM_BYPASS_EN
    exp_d = 32'hFFFF_0000;
`else
    exp_d = 32'hFFFF_FFFF;
`endif
    txn(1'b1, 8'h20, 32'h0, 4'b0011, 1'b1, 8'h20);
    for (int i = 0; i < NDUT; i++) begin
      checks++;
      if (got_d[i] !== exp_d || got_c[i] !== 1'b1) begin
        errors++;
        $display("FAIL coll_partial dut%0d: got d=%h c=%b, expected d=%h c=1", i, got_d[i], got_c[i], exp_d);
      end
    end
    txn(1'b0, 8'h00, 32'h0, 4'h0, 1'b1, 8'h20);
    for (int i = 0; i < NDUT; i++) begin
      checks++;
      if (got_d[i] !== 32'hFFFF_0000 || got_c[i] !== 1'b0) begin
        errors++;
        $display("FAIL coll_after dut%0d: got d=%h c=%b, expected d=ffff0000 c=0", i, got_d[i], got_c[i]);
      end
    end
    // 0xD0 is out of range for the depth-200 instance: no collision there.
    txn(1'b1, 8'hD0, 32'h5555_AAAA, 4'hF, 1'b1, 8'hD0);
    for (int i = 0; i < NDUT; i++) begin
`ifdef SDPRAM_BYPASS_EN
      exp_d = (i == 4) ? 32'h0 : 32'h5555_AAAA;
`else
      exp_d = (i == 4) ? 32'h0 : IV;
`endif
      exp_c = (i != 4);
      checks++;
      if (got_cyc[i] != LAT[i] || got_d[i] !== exp_d || got_c[i] !== exp_c) begin
        errors++;
        $display("FAIL coll_range dut%0d: got cyc=%0d d=%h c=%b, expected cyc=%0d d=%h c=%b",
                 i, got_cyc[i], got_d[i], got_c[i], LAT[i], exp_d, exp_c);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit stray;
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int c = 0; c < 100; c++) step();
    checks++;
    if (busy_a[0] !== 1'b1) begin
      errors++;
      $display("FAIL mid_sweep_busy: got busy=%b at count 100, expected 1", busy_a[0]);
    end
    rst = 1'b1;
    #2;
    for (int i = 0; i < NDUT; i++) begin
      checks++;
      if ({busy_a[i], valid_a[i]} !== 2'b10) begin
        errors++;
        $display("FAIL mid_sweep_rst dut%0d: got busy=%b v=%b, expected busy=1 v=0", i, busy_a[i], valid_a[i]);
      end
    end
    step();
    rst = 1'b0;
    run_sweep(1'b0);
    for (int i = 0; i < NDUT; i++) begin
      checks++;
      if (sweep_cnt[i] != DEP[i]) begin
        errors++;
        $display("FAIL sweep_restart dut%0d: got %0d busy cycles, expected %0d", i, sweep_cnt[i], DEP[i]);
      end
    end
    // Two reads in flight, then reset.
    renb = 1'b1; addrb = 8'h01;
    step();
    addrb = 8'h02;
    step();
    renb = 1'b0;
    rst = 1'b1;
    #1;
    for (int i = 0; i < NDUT; i++) begin
      checks++;
      if ({valid_a[i], coll_a[i], doutb_a[i]} !== {1'b0, 1'b0, 32'h0}) begin
        errors++;
        $display("FAIL inflight_rst dut%0d: got v=%b c=%b d=%h, expected v=0 c=0 d=00000000",
                 i, valid_a[i], coll_a[i], doutb_a[i]);
      end
    end
    step(); step();
    rst = 1'b0;
    run_sweep(1'b0);
    stray = sweep_vld;
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < NDUT; i++) if (valid_a[i] || doutb_a[i] !== 32'h0) stray = 1'b1;
      step();
    end
    checks++;
    if (stray !== 1'b0) begin
      errors++;
      $display("FAIL stale_valid: got stale valid or nonzero doutb after reset, expected none");
    end
  endtask

  // Random traffic checked cycle by cycle on the latency-2 instances
  // (depth 256 and depth 200) against a memory model.
  task automatic test_random();
    logic [31:0] m256 [256];
    logic [31:0] m200 [200];
    logic        cv [2], cc [2], pv [2], pc [2];
    logic [31:0] cd [2], pd [2], last [2];
    logic        we, re, col, inw, inr;
    logic [7:0]  wa, ra;
    logic [31:0] wd, old;
    logic [3:0]  be;
    int          dd, idx;
    for (int a = 0; a < 256; a++) m256[a] = IV;
    for (int a = 0; a < 200; a++) m200[a] = IV;
    for (int j = 0; j < 2; j++) begin pv[j] = 1'b0; pc[j] = 1'b0; pd[j] = '0; last[j] = '0; end
    for (int n = 0; n <= 10000; n++) begin
      if (n < 10000) begin
        we = 1'($urandom_range(0, 1));
        wa = 8'($urandom_range(0, 255));
        re = ($urandom_range(0, 9) < 6);
        ra = ($urandom_range(0, 3) == 0) ? wa : 8'($urandom_range(0, 255));
        wd = $urandom;
        be = 4'($urandom_range(0, 15));
      end else begin
        we = 1'b0; re = 1'b0; wa = 8'h00; ra = 8'h00; wd = 32'h0; be = 4'h0;
      end
      for (int j = 0; j < 2; j++) begin
        dd  = (j == 0) ? 256 : 200;
        inw = 32'(wa) < dd;
        inr = 32'(ra) < dd;
        old = !inr ? 32'h0 : ((j == 0) ? m256[ra] : m200[ra]);
        col = we && re && inw && (wa == ra);
        cv[j] = re;
        cc[j] = col;
`ifdef SDPRAM_BYPASS_EN
        cd[j] = col ? 32'(lane_merge(LM_DW'(old), LM_DW'(wd), LM_NB'(be), 8)) : old;
`else
        cd[j] = old;
`endif
      end
      if (we) begin
        m256[wa] = 32'(lane_merge(LM_DW'(m256[wa]), LM_DW'(wd), LM_NB'(be), 8));
        if (wa < 8'd200) m200[wa] = 32'(lane_merge(LM_DW'(m200[wa]), LM_DW'(wd), LM_NB'(be), 8));
      end
      wena = we; addra = wa; dina = wd; wbe = be; renb = re; addrb = ra;
      step();
      for (int j = 0; j < 2; j++) begin
        idx = (j == 0) ? 0 : 4;
        if (pv[j]) last[j] = pd[j];
        checks++;
        if ({valid_a[idx], coll_a[idx], doutb_a[idx]} !== {pv[j], pv[j] & pc[j], last[j]}) begin
          errors++;
          $display("FAIL random dut%0d n=%0d: got v=%b c=%b d=%h, expected v=%b c=%b d=%h",
                   idx, n, valid_a[idx], coll_a[idx], doutb_a[idx], pv[j], pv[j] & pc[j], last[j]);
        end
        pv[j] = cv[j]; pc[j] = cc[j]; pd[j] = cd[j];
      end
    end
    wena = 1'b0;
    renb = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wena = 1'b0; renb = 1'b0;
    addra = 8'h00; addrb = 8'h00; dina = 32'h0; wbe = 4'h0;
    test_reset();
    test_init_sweep();
    test_byte_enables();
    test_latency();
    test_collision();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdpram_pipe.md
# sdpram_pipe

Parametrised simple dual-port RAM: one write port with per-byte write enables, one read port with configurable pipelined read latency and a read-valid strobe. It adds a post-reset memory-initialisation sweep and same-address collision reporting, with optional write-to-read forwarding. It is a drop-in storage block for buffers and lookup tables on a single clock domain.

## Interface
- DATA_WIDTH, 32, word width in bits; must be a multiple of BYTE_WIDTH
- BYTE_WIDTH, 8, bits per write-enable lane
- MEM_DEPTH, 256, number of words; need not be a power of two
- ADDR_WIDTH, $clog2(MEM_DEPTH), address width
- READ_LATENCY, 2, cycles from read request to data; legal range 1..4
- INIT_VALUE, '0, word written to every location by the init sweep
- NB (localparam), DATA_WIDTH/BYTE_WIDTH, number of byte lanes

Ports:
- clk  in  1  single clock; all logic on its rising edge
- rst  in  1  reset, asynchronous, active-high
- init_busy  out  1  high while the init sweep runs
- wena  in  1  write request
- addra  in  ADDR_WIDTH  write address
- dina  in  DATA_WIDTH  write data
- wbe  in  NB  byte-lane write enables; bit i covers dina[i*BYTE_WIDTH +: BYTE_WIDTH]
- renb  in  1  read request
- addrb  in  ADDR_WIDTH  read address
- doutb  out  DATA_WIDTH  read data
- doutb_valid  out  1  one-cycle strobe marking doutb as valid
- coll  out  1  collision flag, aligned with doutb_valid

## Operation
- Two-state control FSM: INIT and READY.
- While rst is high: state goes to INIT, sweep counter = 0, all pipeline valid bits = 0.
- Reset values: doutb = 0, doutb_valid = 0, coll = 0, init_busy = 1.
- Array contents are not reset directly; only the sweep clears them.
- INIT state:
  - Each cycle, INIT_VALUE is written to address counter, then the counter increments.
  - After address MEM_DEPTH-1 is written, the FSM moves to READY.
  - wena and renb are ignored; no doutb_valid is generated.
  - Asserting rst mid-sweep restarts the sweep from address 0.
- Write (READY state only): when wena=1 and addra < MEM_DEPTH, each lane with wbe[i]=1 is updated at the clock edge.
  - Lanes with wbe[i]=0 keep their value.
  - wbe = 0 is a legal no-op.
  - addra ≥ MEM_DEPTH: the write is dropped.
- Read (READY state only): when renb=1 the request is accepted.
  - addrb ≥ MEM_DEPTH returns 0 with a normal valid strobe.
  - Back-to-back reads are accepted every cycle; there is no backpressure.
- Collision: wena=1 and renb=1 in the same cycle with addra == addrb (and in range).
  - Reported on coll together with that read's doutb_valid.
  - Data returned is set by the SDPRAM_BYPASS_EN macro (see Configuration).
  - A write with wbe = 0 still counts as a collision.
- doutb holds its last value when doutb_valid = 0.

## Timing
- A read accepted at edge N produces doutb and doutb_valid=1 during the cycle after edge N+READ_LATENCY-1.
  - This is READ_LATENCY registered stages: stage 1 is the array read register, stages 2..4 are pipeline registers.
- Valid and coll travel in shift registers alongside the data.
- A write at edge N is visible to a read accepted at edge N+1 or later.
- Sweep length: init_busy is high for MEM_DEPTH cycles after rst deasserts, then falls.
  - First accepted request: the edge at which init_busy is seen low.
- A read in flight when rst asserts is discarded; its valid never appears.

## Configuration
- SDPRAM_BYPASS_EN defined: a colliding read returns merged data.
  - Lanes with wbe=1 come from dina; other lanes come from the old word.
  - This is new-data / write-first behaviour.
- SDPRAM_BYPASS_EN undefined: a colliding read returns the old word (read-first).
- coll behaves identically in both builds.

## Structure
- Package sdpram_pkg:
  - state enum typedef (INIT, READY)
  - READ_LATENCY range constants (min 1, max 4)
  - function lane_merge(old, new, be) used by the bypass path and by the bench model
- Natural sub-module: sdpram_rd_pipe, a parametrised data+valid+coll delay line of depth READ_LATENCY-1.
- The array, write port and FSM stay in sdpram_pipe.

## Test plan
- Init sweep: INIT_VALUE=32'hDEAD_BEEF, MEM_DEPTH=256, rst pulse -> init_busy high exactly 256 cycles; a read of 0x00 and of 0xFF each returns 32'hDEAD_BEEF.
- Byte enables: write 32'h1122_3344 with wbe=4'hF to 0x10, then 32'hAABB_CCDD with wbe=4'b0101 to 0x10 -> a read of 0x10 returns 32'h11BB_33DD.
- Latency sweep, READ_LATENCY = 1..4: back-to-back reads of 0x01..0x08 -> eight consecutive doutb_valid pulses, the first exactly READ_LATENCY cycles after the first request, data in order.
- Collision: location 0x20 holds 32'h0; in one cycle write 32'hFFFF_FFFF with wbe=4'hF and read 0x20 -> coll=1; doutb = 32'h0 without SDPRAM_BYPASS_EN, 32'hFFFF_FFFF with it.
- Reset mid-operation: assert rst during the sweep at count 100, and again with 2 reads in flight -> sweep restarts from 0, no stale doutb_valid, doutb = 0.
- Random regression: 10000 random wena/wbe/renb/addr against a lane_merge reference model -> zero mismatches, and MEM_DEPTH=200 with out-of-range reads returning 0.
